// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared types for the load/store stage.
//               - size_e  : op_size encodings for byte / half / word / reserved
//               - state_e : transaction FSM states
//               - op_illegal() : misaligned / illegal access detection
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    // Width of the BUSY-cycle timeout counter.
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // An access is illegal when it is both a load and a store, uses the
    // reserved size, or is not naturally aligned for its size.
    function automatic logic op_illegal(
        input logic       rd,
        input logic       wr,
        input size_e      sz,
        input logic [1:0] off
    );
        logic bad;
        bad = rd & wr;
        case (sz)
            SZ_BYTE: bad = bad;
            SZ_HALF: bad = bad | off[0];
            SZ_WORD: bad = bad | (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_if
// Description : Data-memory req/ack bus.
//   dmem_req   : request, held until dmem_ack
//   dmem_we    : 1 = write
//   dmem_addr  : word-aligned address
//   dmem_be    : byte enables, bit i = byte lane i (little-endian)
//   dmem_wdata : lane-replicated store data
//   dmem_rdata : read data, valid with dmem_ack
//   dmem_ack   : transaction complete
//   master modport : the load/store stage
//   slave  modport : the data memory
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );

endinterface
`default_nettype wire

// File: rtl/mem_access_ls_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ls_align
// Description : Combinational byte-lane steering for the load/store stage.
//   Store side : op_read/op_write/op_size/addr_off/wdata
//                -> be (byte enables), lane_wdata (replicated data), illegal
//   Load side  : rdata/rd_off/rd_size/rd_unsigned
//                -> ld_data (aligned, sign/zero-extended)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ls_align
    import mem_access_pkg::*;
(
    input  wire logic        op_read,
    input  wire logic        op_write,
    input  wire size_e       op_size,
    input  wire logic [1:0]  addr_off,
    input  wire logic [31:0] wdata,
    output logic      [3:0]  be,
    output logic      [31:0] lane_wdata,
    output logic             illegal,

    input  wire logic [31:0] rdata,
    input  wire logic [1:0]  rd_off,
    input  wire size_e       rd_size,
    input  wire logic        rd_unsigned,
    output logic      [31:0] ld_data
);

    logic [7:0]  w_byte_sel;
    logic [15:0] w_half_sel;

    // ------------------------------------------------------------------
    // Store side
    // ------------------------------------------------------------------
    always_comb begin
        be         = 4'b0000;
        lane_wdata = wdata;
        case (op_size)
            SZ_BYTE: begin
                be         = 4'b0001 << addr_off;
                lane_wdata = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be         = 4'b0011 << addr_off;
                lane_wdata = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                be         = 4'b1111;
                lane_wdata = wdata;
            end
            default: begin
                be         = 4'b0000;
                lane_wdata = wdata;
            end
        endcase
    end

    assign illegal = op_illegal(op_read, op_write, op_size, addr_off);

    // ------------------------------------------------------------------
    // Load side
    // ------------------------------------------------------------------
    assign w_byte_sel = rdata[{rd_off, 3'b000} +: 8];
    // Only offsets 0 and 2 reach here for halves; bit 1 picks the lane pair.
    assign w_half_sel = rd_off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        ld_data = rdata;
        case (rd_size)
            SZ_BYTE: ld_data = rd_unsigned ? {24'h000000, w_byte_sel}
                                           : {{24{w_byte_sel[7]}}, w_byte_sel};
            SZ_HALF: ld_data = rd_unsigned ? {16'h0000, w_half_sel}
                                           : {{16{w_half_sel[15]}}, w_half_sel};
            default: ld_data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : Load/store stage downstream of the ALU. Runs one data-memory
//               transaction per load/store over a req/ack bus, stalls the
//               pipeline meanwhile, and returns the aligned, extended load
//               value. Misaligned/illegal accesses are flagged with no bus
//               cycle; a missing ack aborts after TIMEOUT BUSY cycles.
// Ports       :
//   clk_cpu     in  CPU clock, rising edge
//   reset       in  asynchronous, active-low
//   op_valid    in  load/store presented this cycle
//   op_read     in  load
//   op_write    in  store
//   op_size     in  00 byte, 01 half, 10 word, 11 reserved
//   op_unsigned in  1 = zero-extend loads
//   addr        in  effective address
//   wdata       in  store data
//   stall       out hold upstream stages (combinational)
//   ld_valid    out 1-cycle pulse, ld_data valid
//   ld_data     out extended load result (holds between pulses)
//   err_access  out 1-cycle pulse, misaligned/illegal op
//   err_timeout out 1-cycle pulse, bus gave no ack
//   dmem        --  data-memory bus (master side)
// Parameters  : TIMEOUT - max BUSY cycles without ack (1..255)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  wire logic        clk_cpu,
    input  wire logic        reset,

    input  wire logic        op_valid,
    input  wire logic        op_read,
    input  wire logic        op_write,
    input  wire logic [1:0]  op_size,
    input  wire logic        op_unsigned,
    input  wire logic [31:0] addr,
    input  wire logic [31:0] wdata,

    output logic             stall,
    output logic             ld_valid,
    output logic      [31:0] ld_data,
    output logic             err_access,
    output logic             err_timeout,

    mem_access_if.master     dmem
);

    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT - 1);

    // FSM and latched op
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_q, rd_d;
    size_e             size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;

    // Registered bus outputs
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       baddr_q, baddr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       bwdata_q, bwdata_d;

    // Registered result outputs
    logic              ld_valid_q, ld_valid_d;
    logic [31:0]       ld_data_q, ld_data_d;
    logic              err_acc_q, err_acc_d;
    logic              err_to_q, err_to_d;

    // Alignment network
    size_e             w_op_size;
    logic              w_accept;
    logic [3:0]        w_be;
    logic [31:0]       w_lane_wdata;
    logic              w_illegal;
    logic [31:0]       w_ld_ext;

    assign w_op_size = size_e'(op_size);
    assign w_accept  = op_valid & (op_read | op_write);

    // Store steering uses the live op (captured on accept); load extraction
    // uses the latched op since rdata arrives later.
    mem_access_ls_align u_align (
        .op_read     (op_read),
        .op_write    (op_write),
        .op_size     (w_op_size),
        .addr_off    (addr[1:0]),
        .wdata       (wdata),
        .be          (w_be),
        .lane_wdata  (w_lane_wdata),
        .illegal     (w_illegal),
        .rdata       (dmem.dmem_rdata),
        .rd_off      (off_q),
        .rd_size     (size_q),
        .rd_unsigned (uns_q),
        .ld_data     (w_ld_ext)
    );

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        size_d     = size_q;
        uns_d      = uns_q;
        off_d      = off_q;
        req_d      = req_q;
        we_d       = we_q;
        baddr_d    = baddr_q;
        be_d       = be_q;
        bwdata_d   = bwdata_q;
        ld_data_d  = ld_data_q;
        ld_valid_d = 1'b0;
        err_acc_d  = 1'b0;
        err_to_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    rd_d   = op_read;
                    size_d = w_op_size;
                    uns_d  = op_unsigned;
                    off_d  = addr[1:0];
                    if (w_illegal) begin
                        err_acc_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        req_d    = 1'b1;
                        we_d     = op_write;
                        baddr_d  = {addr[31:2], 2'b00};
                        be_d     = w_be;
                        bwdata_d = w_lane_wdata;
                        cnt_d    = '0;
                        state_d  = ST_BUSY;
                    end
                end
            end

            ST_BUSY: begin
                // An ack in the final allowed cycle still completes normally.
                if (dmem.dmem_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                    if (rd_q) begin
                        ld_valid_d = 1'b1;
                        ld_data_d  = w_ld_ext;
                    end
                end else if (cnt_q == c_timeout_last) begin
                    req_d    = 1'b0;
                    err_to_d = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                // The same instruction is still presented here; do not
                // re-accept it.
                state_d = ST_IDLE;
            end

            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rd_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            uns_q      <= 1'b0;
            off_q      <= 2'b00;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            baddr_q    <= 32'h0;
            be_q       <= 4'h0;
            bwdata_q   <= 32'h0;
            ld_valid_q <= 1'b0;
            ld_data_q  <= 32'h0;
            err_acc_q  <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            off_q      <= off_d;
            req_q      <= req_d;
            we_q       <= we_d;
            baddr_q    <= baddr_d;
            be_q       <= be_d;
            bwdata_q   <= bwdata_d;
            ld_valid_q <= ld_valid_d;
            ld_data_q  <= ld_data_d;
            err_acc_q  <= err_acc_d;
            err_to_q   <= err_to_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Gated by reset so a held op_valid cannot raise stall while in reset.
    assign stall = reset & (((state_q == ST_IDLE) & w_accept) | (state_q == ST_BUSY));

    assign ld_valid    = ld_valid_q;
    assign ld_data     = ld_data_q;
    assign err_access  = err_acc_q;
    assign err_timeout = err_to_q;

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = baddr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = bwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Directed testbench for mem_access (TIMEOUT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    logic        clk_cpu;
    logic        reset;
    logic        op_valid;
    logic        op_read;
    logic        op_write;
    logic [1:0]  op_size;
    logic        op_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        err_access;
    logic        err_timeout;

    int total = 0;
    int bad   = 0;

    mem_access_if bus ();

    mem_access #(.TIMEOUT(4)) dut (
        .clk_cpu     (clk_cpu),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_read     (op_read),
        .op_write    (op_write),
        .op_size     (op_size),
        .op_unsigned (op_unsigned),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .err_access  (err_access),
        .err_timeout (err_timeout),
        .dmem        (bus)
    );

    initial clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    task automatic present(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd);
        op_valid = 1'b1; op_read = rd; op_write = wr; op_size = sz;
        op_unsigned = uns; addr = a; wdata = wd;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0; op_valid = 1'b0; op_read = 1'b0; op_write = 1'b0;
        op_size = 2'b00; op_unsigned = 1'b0; addr = 32'h0; wdata = 32'h0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
        repeat (2) @(negedge clk_cpu);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", stall); end
        total++; if (ld_valid !== 1'b0 || err_access !== 1'b0 || err_timeout !== 1'b0) begin
            bad++; $display("FAIL rst_pulses: got %b%b%b want 000", ld_valid, err_access, err_timeout); end
        total++; if (ld_data !== 32'h0) begin bad++; $display("FAIL rst_ld_data: got %h want 0", ld_data); end
        total++; if ({bus.dmem_req, bus.dmem_we, bus.dmem_be} !== 6'b0) begin
            bad++; $display("FAIL rst_bus_ctl: got %b want 0", {bus.dmem_req, bus.dmem_we, bus.dmem_be}); end
        total++; if (bus.dmem_addr !== 32'h0 || bus.dmem_wdata !== 32'h0) begin
            bad++; $display("FAIL rst_bus_data: got %h/%h want 0/0", bus.dmem_addr, bus.dmem_wdata); end
        reset = 1'b1;
        @(negedge clk_cpu);
    endtask

    // ------------------------------------------------------------------
    task automatic test_load_word();
        present(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL lw_stall_accept: got %b want 1", stall); end
        total++; if (bus.dmem_req !== 1'b0) begin bad++; $display("FAIL lw_req_accept: got %b want 0", bus.dmem_req); end
        @(negedge clk_cpu);
        total++; if (bus.dmem_req !== 1'b1 || stall !== 1'b1) begin
            bad++; $display("FAIL lw_busy: got req=%b stall=%b want 1/1", bus.dmem_req, stall); end
        total++; if (bus.dmem_addr !== 32'h100 || bus.dmem_be !== 4'b1111 || bus.dmem_we !== 1'b0) begin
            bad++; $display("FAIL lw_bus: got %h %b %b want 00000100 1111 0", bus.dmem_addr, bus.dmem_be, bus.dmem_we); end
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hDEADBEEF;
        @(negedge clk_cpu);
        bus.dmem_ack = 1'b0;
        total++; if (ld_valid !== 1'b1) begin bad++; $display("FAIL lw_ld_valid: got %b want 1", ld_valid); end
        total++; if (ld_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_ld_data: got %h want deadbeef", ld_data); end
        total++; if (bus.dmem_req !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL lw_done: got req=%b stall=%b want 0/0", bus.dmem_req, stall); end
        op_valid = 1'b0;
        @(negedge clk_cpu);
        total++; if (ld_valid !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL lw_after: got ld_valid=%b stall=%b want 0/0", ld_valid, stall); end
        total++; if (ld_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_hold: got %h want deadbeef", ld_data); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_load_extend();
        logic [1:0]  v_sz  [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
        logic        v_uns [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] v_addr[6] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101, 32'h104};
        logic [31:0] v_rd  [6] = '{32'h80000000, 32'h80000000, 32'hBEEF1234,
                                   32'h1234F00D, 32'h00007F00, 32'h80000001};
        logic [3:0]  v_be  [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010, 4'b1111};
        logic [31:0] v_exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFBEEF,
                                   32'hFFFFF00D, 32'h0000007F, 32'h80000001};
        for (int i = 0; i < 6; i++) begin
            present(1'b1, 1'b0, v_sz[i], v_uns[i], v_addr[i], 32'h0);
            @(negedge clk_cpu);
            total++; if (bus.dmem_be !== v_be[i] || bus.dmem_addr !== {v_addr[i][31:2], 2'b00}) begin
                bad++; $display("FAIL ld%0d_bus: got be=%b addr=%h want be=%b", i, bus.dmem_be, bus.dmem_addr, v_be[i]); end
            bus.dmem_ack = 1'b1; bus.dmem_rdata = v_rd[i];
            @(negedge clk_cpu);
            bus.dmem_ack = 1'b0;
            total++; if (ld_valid !== 1'b1 || ld_data !== v_exp[i]) begin
                bad++; $display("FAIL ld%0d_data: got v=%b d=%h want v=1 d=%h", i, ld_valid, ld_data, v_exp[i]); end
            op_valid = 1'b0;
            @(negedge clk_cpu);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_store();
        logic [1:0]  v_sz  [4] = '{2'b01, 2'b00, 2'b10, 2'b00};
        logic [31:0] v_addr[4] = '{32'h202, 32'h101, 32'h10, 32'h203};
        logic [31:0] v_wd  [4] = '{32'h1234ABCD, 32'h0000005A, 32'hCAFEBABE, 32'h123456C3};
        logic [31:0] v_ba  [4] = '{32'h200, 32'h100, 32'h10, 32'h200};
        logic [3:0]  v_be  [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
        logic [31:0] v_bw  [4] = '{32'hABCDABCD, 32'h5A5A5A5A, 32'hCAFEBABE, 32'hC3C3C3C3};
        for (int i = 0; i < 4; i++) begin
            present(1'b0, 1'b1, v_sz[i], 1'b0, v_addr[i], v_wd[i]);
            @(negedge clk_cpu);
            total++; if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1) begin
                bad++; $display("FAIL st%0d_req: got req=%b we=%b want 1/1", i, bus.dmem_req, bus.dmem_we); end
            total++; if (bus.dmem_addr !== v_ba[i] || bus.dmem_be !== v_be[i] || bus.dmem_wdata !== v_bw[i]) begin
                bad++; $display("FAIL st%0d_bus: got %h %b %h want %h %b %h", i, bus.dmem_addr, bus.dmem_be,
                                bus.dmem_wdata, v_ba[i], v_be[i], v_bw[i]); end
            bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h55555555;
            @(negedge clk_cpu);
            bus.dmem_ack = 1'b0;
            total++; if (ld_valid !== 1'b0 || err_access !== 1'b0 || err_timeout !== 1'b0 || stall !== 1'b0) begin
                bad++; $display("FAIL st%0d_done: got v=%b ea=%b et=%b stall=%b want 0000", i, ld_valid,
                                err_access, err_timeout, stall); end
            op_valid = 1'b0;
            @(negedge clk_cpu);
        end
        // Last load in test_load_extend returned 0x80000001; stores must not disturb it.
        total++; if (ld_data !== 32'h80000001) begin bad++; $display("FAIL st_ld_hold: got %h want 80000001", ld_data); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_access_error();
        logic        v_rd  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        v_wr  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0]  v_sz  [5] = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b10};
        logic [31:0] v_addr[5] = '{32'h101, 32'h100, 32'h100, 32'h103, 32'h102};
        for (int i = 0; i < 5; i++) begin
            present(v_rd[i], v_wr[i], v_sz[i], 1'b0, v_addr[i], 32'h0);
            #1;
            total++; if (stall !== 1'b1) begin bad++; $display("FAIL err%0d_stall: got %b want 1", i, stall); end
            @(negedge clk_cpu);
            total++; if (err_access !== 1'b1 || bus.dmem_req !== 1'b0 || stall !== 1'b0 || ld_valid !== 1'b0) begin
                bad++; $display("FAIL err%0d_pulse: got ea=%b req=%b stall=%b v=%b want 1000", i, err_access,
                                bus.dmem_req, stall, ld_valid); end
            op_valid = 1'b0;
            @(negedge clk_cpu);
            total++; if (err_access !== 1'b0 || bus.dmem_req !== 1'b0) begin
                bad++; $display("FAIL err%0d_after: got ea=%b req=%b want 0/0", i, err_access, bus.dmem_req); end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_timeout();
        int req_cycles = 0;
        present(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_cpu);
            if (bus.dmem_req === 1'b1 && stall === 1'b1) req_cycles++;
        end
        total++; if (req_cycles != 4) begin bad++; $display("FAIL to_req_cycles: got %0d want 4", req_cycles); end
        @(negedge clk_cpu);
        total++; if (bus.dmem_req !== 1'b0 || err_timeout !== 1'b1 || stall !== 1'b0 || ld_valid !== 1'b0) begin
            bad++; $display("FAIL to_pulse: got req=%b et=%b stall=%b v=%b want 0100", bus.dmem_req,
                            err_timeout, stall, ld_valid); end
        op_valid = 1'b0;
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h12345678;
        @(negedge clk_cpu);
        total++; if (err_timeout !== 1'b0 || bus.dmem_req !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL to_idle: got et=%b req=%b stall=%b want 000", err_timeout, bus.dmem_req, stall); end
        @(negedge clk_cpu);
        bus.dmem_ack = 1'b0;
        total++; if (ld_valid !== 1'b0 || ld_data !== 32'h80000001) begin
            bad++; $display("FAIL to_late_ack: got v=%b d=%h want 0 80000001", ld_valid, ld_data); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_busy();
        present(1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
        @(negedge clk_cpu);
        total++; if (bus.dmem_req !== 1'b1) begin bad++; $display("FAIL rb_req: got %b want 1", bus.dmem_req); end
        #2 reset = 1'b0;
        #1;
        total++; if (bus.dmem_req !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL rb_async: got req=%b stall=%b want 0/0", bus.dmem_req, stall); end
        total++; if (ld_data !== 32'h0 || bus.dmem_addr !== 32'h0 || bus.dmem_be !== 4'h0 || ld_valid !== 1'b0) begin
            bad++; $display("FAIL rb_outs: got d=%h a=%h be=%b v=%b want all 0", ld_data, bus.dmem_addr,
                            bus.dmem_be, ld_valid); end
        @(negedge clk_cpu);
        op_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk_cpu);
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        present(1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
        @(negedge clk_cpu);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h0BADF00D;
        @(negedge clk_cpu);
        bus.dmem_ack = 1'b0;
        total++; if (ld_valid !== 1'b1 || ld_data !== 32'h0BADF00D) begin
            bad++; $display("FAIL b2b_first: got v=%b d=%h want 1 0badf00d", ld_valid, ld_data); end
        // Next instruction presented as soon as the pipeline advances.
        present(1'b1, 1'b0, 2'b00, 1'b1, 32'h86, 32'h0);
        @(negedge clk_cpu);
        total++; if (stall !== 1'b1 || bus.dmem_req !== 1'b0 || ld_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_accept: got stall=%b req=%b v=%b want 100", stall, bus.dmem_req, ld_valid); end
        @(negedge clk_cpu);
        total++; if (bus.dmem_req !== 1'b1 || bus.dmem_be !== 4'b0100 || bus.dmem_addr !== 32'h84) begin
            bad++; $display("FAIL b2b_bus: got req=%b be=%b a=%h want 1 0100 00000084", bus.dmem_req,
                            bus.dmem_be, bus.dmem_addr); end
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h00F10000;
        @(negedge clk_cpu);
        bus.dmem_ack = 1'b0;
        total++; if (ld_valid !== 1'b1 || ld_data !== 32'h000000F1) begin
            bad++; $display("FAIL b2b_second: got v=%b d=%h want 1 000000f1", ld_valid, ld_data); end
        op_valid = 1'b0;
        @(negedge clk_cpu);
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_extend();
        test_store();
        test_access_error();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
